// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with runtime data length, parity and stop-bit count.
// Latency: a word written into an empty FIFO while idle starts its start bit on the next clk edge.
//   Frames are sent back-to-back while words remain queued.
// Backpressure: o_tx_ready drops when the FIFO is full or rst is high. A same-cycle pop does not raise it.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   i_tx_data/_valid    write side of the FIFO; o_tx_ready is the handshake
//   i_div_num           clk cycles per UART bit. Values below 2 are treated as 2.
//   i_data_bit          data bits per frame, clamped to 5..P_DATA_WIDTH
//   i_stop_bit          stop bits: 0 or 1 gives one stop bit; 2 or 3 gives two
//   i_check_bit         parity: 0 none, 1 odd, 2 even, 3 none
//   o_uart_tx           serial line, idle high
//   o_busy              a frame is in progress or the FIFO holds data
//   o_fifo_level        number of words stored
//   o_frame_done        single-cycle pulse during the last cycle of each frame
module uart_tx_fifo #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_FIFO_DEPTH = 16,
  parameter int P_DIV_WIDTH  = 24
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_DATA_WIDTH-1:0]         i_tx_data,
  input  logic                            i_tx_valid,
  output logic                            o_tx_ready,
  input  logic [P_DIV_WIDTH-1:0]          i_div_num,
  input  logic [3:0]                      i_data_bit,
  input  logic [1:0]                      i_stop_bit,
  input  logic [1:0]                      i_check_bit,
  output logic                            o_uart_tx,
  output logic                            o_busy,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_level,
  output logic                            o_frame_done
);

  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]          LP_DEPTH    = LW'(P_FIFO_DEPTH);
  localparam logic [LW-1:0]          LP_LVL_ONE  = LW'(1);
  localparam logic [AW-1:0]          LP_PTR_ONE  = AW'(1);
  localparam logic [P_DIV_WIDTH-1:0] LP_DIV_ONE  = P_DIV_WIDTH'(1);
  localparam logic [P_DIV_WIDTH-1:0] LP_DIV_MIN  = P_DIV_WIDTH'(2);
  localparam logic [3:0]             LP_MAX_BITS = 4'(P_DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [P_DATA_WIDTH-1:0] mem_q [P_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    push, pop;
  logic [P_DATA_WIDTH-1:0] head;

  // Serialiser state; frame config is held stable for the whole frame
  state_t                  state_q, state_d;
  logic [P_DIV_WIDTH-1:0]  div_q, div_d;
  logic [P_DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [3:0]              nbits_q, nbits_d;
  logic [3:0]              bit_cnt_q, bit_cnt_d;
  logic                    two_stop_q, two_stop_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic [P_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                    tx_q, tx_d;

  // Clamped config for the word currently at the FIFO head
  logic [P_DIV_WIDTH-1:0]  cfg_div;
  logic [3:0]              cfg_nbits;
  logic                    cfg_two_stop, cfg_par_en, cfg_par_bit;
  logic                    bit_end, load;

  assign o_tx_ready   = !rst && (level_q < LP_DEPTH);
  assign push         = i_tx_valid && o_tx_ready;
  assign head         = mem_q[rd_ptr_q];
  assign bit_end      = (div_cnt_q == div_q - LP_DIV_ONE);
  assign o_uart_tx    = tx_q;
  assign o_busy       = (state_q != S_IDLE) || (level_q != '0);
  assign o_fifo_level = level_q;

  always_comb begin
    cfg_div = (i_div_num < LP_DIV_MIN) ? LP_DIV_MIN : i_div_num;
    if (i_data_bit < 4'd5) begin
      cfg_nbits = 4'd5;
    end else if (i_data_bit > LP_MAX_BITS) begin
      cfg_nbits = LP_MAX_BITS;
    end else begin
      cfg_nbits = i_data_bit;
    end
    cfg_two_stop = i_stop_bit[1];
    cfg_par_en   = (i_check_bit == 2'd1) || (i_check_bit == 2'd2);
    // Parity covers only the bits actually sent
    cfg_par_bit  = 1'b0;
    for (int i = 0; i < P_DATA_WIDTH; i++) begin
      if (4'(i) < cfg_nbits) cfg_par_bit = cfg_par_bit ^ head[i];
    end
    if (i_check_bit == 2'd1) cfg_par_bit = ~cfg_par_bit;
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    nbits_d      = nbits_q;
    two_stop_d   = two_stop_q;
    par_en_d     = par_en_q;
    par_bit_d    = par_bit_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = bit_end ? '0 : div_cnt_q + LP_DIV_ONE;
    load         = 1'b0;
    o_frame_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_cnt_d = '0;
        if (level_q != '0) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == nbits_q - 4'd1) begin
            bit_cnt_d = '0;
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d   = S_STOP;
          bit_cnt_d = '0;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == {3'b000, two_stop_q}) begin
            o_frame_done = 1'b1;
            // Chain straight into the next start bit when data is waiting
            if (level_q != '0) load = 1'b1;
            else state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      state_d    = S_START;
      tx_d       = 1'b0;
      div_cnt_d  = '0;
      bit_cnt_d  = '0;
      div_d      = cfg_div;
      nbits_d    = cfg_nbits;
      two_stop_d = cfg_two_stop;
      par_en_d   = cfg_par_en;
      par_bit_d  = cfg_par_bit;
      shift_d    = head;
    end
  end

  assign pop = load;

  always_comb begin
    level_d = level_q;
    if (push && !pop) level_d = level_q + LP_LVL_ONE;
    else if (!push && pop) level_d = level_q - LP_LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= i_tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= S_IDLE;
      div_q      <= LP_DIV_MIN;
      div_cnt_q  <= '0;
      nbits_q    <= LP_MAX_BITS;
      bit_cnt_q  <= '0;
      two_stop_q <= 1'b0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + LP_PTR_ONE;
      if (pop) rd_ptr_q <= rd_ptr_q + LP_PTR_ONE;
      level_q    <= level_d;
      state_q    <= state_d;
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      nbits_q    <= nbits_d;
      bit_cnt_q  <= bit_cnt_d;
      two_stop_q <= two_stop_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered, runtime-configurable UART transmitter, the successor to the plain driver TX path. User data enters a parametrised FIFO through a valid/ready handshake. Frames are serialised with runtime-selected data length, parity mode and stop-bit count. Frames leave back-to-back with no idle gap while the FIFO is non-empty.

Parameters:
P_DATA_WIDTH, 8, user data width and maximum data bits per frame (5..8)
P_FIFO_DEPTH, 16, FIFO entries; power of two, >= 2
P_DIV_WIDTH, 24, width of the bit-period divider

Ports:
clk  in  1  system clock
rst  in  1  reset
i_tx_data  in  P_DATA_WIDTH  data to transmit
i_tx_valid  in  1  data valid
o_tx_ready  out  1  FIFO can accept a word
i_div_num  in  P_DIV_WIDTH  clk cycles per UART bit
i_data_bit  in  4  data bits per frame
i_stop_bit  in  2  stop bits (1 or 2)
i_check_bit  in  2  parity: 0 none, 1 odd, 2 even
o_uart_tx  out  1  serial line, idle high
o_busy  out  1  frame in progress or FIFO non-empty
o_fifo_level  out  $clog2(P_FIFO_DEPTH)+1  words stored
o_frame_done  out  1  one-cycle pulse at the end of each frame

Reset is rst, asynchronous, active-high; the clock is clk.

Behaviour:
- Reset values:
  - o_uart_tx=1, o_busy=0, o_fifo_level=0, o_frame_done=0, FSM=IDLE, FIFO pointers cleared.
  - o_tx_ready=0 while rst is high.
  - Reset mid-frame aborts the frame; the line returns high immediately and buffered data is discarded.
- Write side:
  - o_tx_ready = !rst && (level < P_FIFO_DEPTH), combinational from the registered level.
  - A push occurs on a clk edge with i_tx_valid & o_tx_ready.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, ready is 0 even if a pop occurs that cycle.
- Config latch:
  - i_div_num, i_data_bit, i_stop_bit and i_check_bit are sampled only on the cycle a word is popped.
  - Input changes mid-frame do not affect the current frame.
- Config clamping:
  - div < 2 uses 2.
  - data_bit < 5 uses 5; data_bit > P_DATA_WIDTH uses P_DATA_WIDTH.
  - stop 0 uses 1; stop 3 uses 2.
  - check 3 uses none.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if level > 0, pop the head word, latch config, set o_uart_tx=0 on that edge, go to START.
  - A word pushed at edge k into an empty FIFO while IDLE produces the start-bit falling edge at edge k+1.
  - START: hold 0 for div cycles, then go to DATA.
  - DATA: N bits LSB first, each held div cycles; a bit counter runs 0..N-1. Then PARITY if parity is enabled, otherwise STOP.
  - PARITY: odd sends ~^data[N-1:0]; even sends ^data[N-1:0]; held div cycles.
  - STOP: hold 1 for S*div cycles.
- End of frame:
  - On the final STOP cycle, o_frame_done pulses for 1 cycle.
  - If the FIFO is non-empty on that cycle, pop and go directly to START, with no idle bit inserted. Otherwise go to IDLE.
- Timing and status:
  - Frame length is exactly (1+N+P+S)*div clk cycles.
  - The bit counter and divider counter reset at every bit boundary.
  - o_busy = (state != IDLE) || (level != 0).
  - Data bits above N in the FIFO word are ignored.

Test Plan:
- 8N1, div=50; push 0xA5 into an empty FIFO when IDLE -> tx falls 1 cycle after the handshake; bits 1,0,1,0,0,1,0,1 at 50 cycles each; 500-cycle frame; o_frame_done pulse at cycle 500; o_busy drops the cycle after.
- 8N1, div=50; push 20 incrementing bytes 0x00.. with valid held high -> level reaches 16 and ready=0 until the first pop; all 20 frames are contiguous (10,000 cycles) with no high gap between stop and start; received bytes 0x00..0x13 in order.
- 7 data, odd parity, 2 stop (7O2), div=50, byte 0x35 -> data 1,0,1,0,1,1,0, parity 1, two stop bits; 550-cycle frame.
- 8E1, byte 0xA5 -> parity bit 0; byte 0xA4 -> parity bit 1; 550 cycles each.
- Change i_div_num 50->100 and i_check_bit 0->2 mid-frame with a second byte queued -> first frame stays 500 cycles with no parity; second frame is 1,100 cycles with parity.
- Assert rst at cycle 200 of a frame with 3 bytes queued -> o_uart_tx=1 immediately, level=0, ready=0 during reset; after release, no frame is emitted until a new push.
- Clamp check: div=1, data_bit=3, stop=0, check=3, byte 0xFF -> 5-bit, no-parity, 1-stop frame at 2 cycles/bit, 14 cycles total.
